// File: rtl/ext_msg_bank_ram_if.sv
// Port bundle for the multi-lane extrinsic-message bank: clear control,
// read port, masked write port and the sticky access error flag.
interface ext_msg_bank_ram_if #(
    parameter int DATA_WIDTH = 5,
    parameter int ADDR_WIDTH = 8,
    parameter int LANES      = 4
);
    logic                          clear_start;
    logic                          clear_busy;
    logic                          clear_done;
    logic                          rd_en;
    logic [ADDR_WIDTH-1:0]         rd_addr;
    logic [LANES*DATA_WIDTH-1:0]   rd_data;
    logic                          rd_valid;
    logic                          wr_en;
    logic [ADDR_WIDTH-1:0]         wr_addr;
    logic [LANES*DATA_WIDTH-1:0]   wr_data;
    logic [LANES-1:0]              wr_lane_mask;
    logic                          access_err;

    modport master (
        output clear_start, rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_lane_mask,
        input  clear_busy, clear_done, rd_data, rd_valid, access_err
    );

    modport slave (
        input  clear_start, rd_en, rd_addr, wr_en, wr_addr, wr_data, wr_lane_mask,
        output clear_busy, clear_done, rd_data, rd_valid, access_err
    );
endinterface

// File: rtl/ext_msg_bank_ram.sv
// LANES-wide check-to-variable message store with per-lane write masking,
// write-first bypass on collision and a self-running clear sequencer.
module ext_msg_bank_ram #(
    parameter int                    DATA_WIDTH  = 5,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    RAM_DEPTH   = 1 << ADDR_WIDTH,
    parameter int                    LANES       = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input logic               clk,
    input logic               rst,
    ext_msg_bank_ram_if.slave bus
);

    localparam int WORD_W = LANES * DATA_WIDTH;
    localparam int IDX_W  = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    clear_cnt;
    logic [WORD_W-1:0]   mem [RAM_DEPTH];

    logic                rd_in_range;
    logic                wr_in_range;
    logic                rd_acc;
    logic                wr_acc;
    logic                collide;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    wr_idx;
    logic [WORD_W-1:0]   rd_word_p0;

    assign rd_idx      = bus.rd_addr[IDX_W-1:0];
    assign wr_idx      = bus.wr_addr[IDX_W-1:0];
    assign rd_in_range = 32'(bus.rd_addr) < 32'(RAM_DEPTH);
    assign wr_in_range = 32'(bus.wr_addr) < 32'(RAM_DEPTH);
    assign rd_acc      = (state == IDLE) && bus.rd_en;
    assign wr_acc      = (state == IDLE) && bus.wr_en && wr_in_range;
    assign collide     = wr_acc && (bus.wr_addr == bus.rd_addr);

    // ---- stage p0: array lookup with per-lane write-first bypass ----
    always_comb begin
        rd_word_p0 = rd_in_range ? mem[rd_idx] : '0;
        for (int k = 0; k < LANES; k++) begin
            if (collide && bus.wr_lane_mask[k]) begin
                rd_word_p0[k*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Storage is never reset; the sequencer owns it whenever state is CLEAR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clear_cnt] <= {LANES{CLEAR_VALUE}};
            end else if (wr_acc) begin
                for (int k = 0; k < LANES; k++) begin
                    if (bus.wr_lane_mask[k]) begin
                        mem[wr_idx][k*DATA_WIDTH +: DATA_WIDTH] <= bus.wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // ---- stage p1: registered read word, valid and clear sequencer ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= CLEAR;
            clear_cnt      <= '0;
            bus.clear_busy <= 1'b1;
            bus.clear_done <= 1'b0;
            bus.access_err <= 1'b0;
            bus.rd_valid   <= 1'b0;
            bus.rd_data    <= '0;
        end else begin
            bus.clear_done <= 1'b0;
            bus.rd_valid   <= rd_acc;
            if (rd_acc) begin
                bus.rd_data <= rd_word_p0;
            end
            case (state)
                CLEAR: begin
                    if (bus.rd_en || bus.wr_en) begin
                        bus.access_err <= 1'b1;
                    end
                    if (clear_cnt == LAST_IDX) begin
                        state          <= IDLE;
                        bus.clear_busy <= 1'b0;
                        bus.clear_done <= 1'b1;
                    end else begin
                        clear_cnt <= clear_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.clear_start) begin
                        state          <= CLEAR;
                        clear_cnt      <= '0;
                        bus.clear_busy <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ext_msg_bank_ram.sv
// Directed bench for ext_msg_bank_ram: expected read words are queued when a
// read is issued and compared when rd_valid is due one cycle later.
module tb_ext_msg_bank_ram;

    localparam int DW    = 5;
    localparam int AW    = 8;
    localparam int DEPTH = 16;
    localparam int NL    = 4;

    typedef struct {
        logic [19:0] data;
        logic        care;
        int          addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int errors = 0;
    int checks = 0;

    exp_t        exp_q[$];
    logic        exp_acc = 1'b0;
    logic [19:0] exp_hold = '0;
    logic [19:0] ref_mem [DEPTH];

    always #5 clk = ~clk;

    ext_msg_bank_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(NL)) bus ();

    ext_msg_bank_ram #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH),
        .LANES      (NL),
        .CLEAR_VALUE(5'h1F)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then release one-shot requests and score the read port.
    task automatic tick();
        logic v;
        exp_t e;
        @(posedge clk);
        v       = exp_acc;
        exp_acc = 1'b0;
        #1;
        bus.rd_en       = 1'b0;
        bus.wr_en       = 1'b0;
        bus.clear_start = 1'b0;
        chk("rd_valid", 32'(bus.rd_valid), 32'(v));
        if (v && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.care) begin
                chk($sformatf("rd_data@%0d", e.addr), 32'(bus.rd_data), 32'(e.data));
                exp_hold = e.data;
            end
        end
    endtask

    task automatic do_write(input logic [7:0] a, input logic [19:0] d, input logic [3:0] m);
        bus.wr_en        = 1'b1;
        bus.wr_addr      = a;
        bus.wr_data      = d;
        bus.wr_lane_mask = m;
        if (int'(a) < DEPTH) begin
            for (int k = 0; k < NL; k++) begin
                if (m[k]) ref_mem[a][k*DW +: DW] = d[k*DW +: DW];
            end
        end
    endtask

    task automatic do_read_exp(input logic [7:0] a, input logic [19:0] d, input logic care);
        exp_t e;
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        exp_acc     = 1'b1;
        e.data = d;
        e.care = care;
        e.addr = int'(a);
        exp_q.push_back(e);
    endtask

    task automatic do_read(input logic [7:0] a);
        do_read_exp(a, ref_mem[a[3:0]], 1'b1);
    endtask

    task automatic busy_ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_busy"}, 32'(bus.clear_busy), 32'd1);
            chk({tag, "_done"}, 32'(bus.clear_done), 32'd0);
        end
    endtask

    task automatic finish_clear(input string tag);
        tick();
        chk({tag, "_busy_end"}, 32'(bus.clear_busy), 32'd0);
        chk({tag, "_done_pulse"}, 32'(bus.clear_done), 32'd1);
        tick();
        chk({tag, "_done_low"}, 32'(bus.clear_done), 32'd0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 20'hFFFFF;
    endtask

    initial begin
        logic [19:0] pat;
        bus.clear_start  = 1'b0;
        bus.rd_en        = 1'b0;
        bus.rd_addr      = '0;
        bus.wr_en        = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.wr_lane_mask = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 'x;

        // Reset values, then the automatic clear after release
        #1 rst = 1'b1;
        #1;
        chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_busy", 32'(bus.clear_busy), 32'd1);
        chk("rst_done", 32'(bus.clear_done), 32'd0);
        chk("rst_err", 32'(bus.access_err), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        busy_ticks("clr0", DEPTH - 1);
        finish_clear("clr0");
        for (int i = 0; i < DEPTH; i++) begin
            do_read_exp(8'(i), 20'hFFFFF, 1'b1);
            tick();
        end
        tick();
        chk("rd_hold0", 32'(bus.rd_data), 32'hFFFFF);

        // Masked overwrite of address 3
        do_write(8'd3, 20'h12345, 4'b1111);
        tick();
        do_write(8'd3, 20'h0ABCD, 4'b0101);
        tick();
        do_read_exp(8'd3, 20'h12B4D, 1'b1);
        tick();

        // Same-cycle collision on address 7, then a plain re-read
        do_write(8'd7, 20'h00000, 4'b0011);
        do_read_exp(8'd7, 20'hFFC00, 1'b1);
        tick();
        do_read_exp(8'd7, 20'hFFC00, 1'b1);
        tick();

        // Empty mask is a no-op; out-of-range write is dropped; out-of-range read is valid
        do_write(8'd7, 20'h12345, 4'b0000);
        tick();
        do_read_exp(8'd7, 20'hFFC00, 1'b1);
        tick();
        do_write(8'h13, 20'h00000, 4'b1111);
        do_read_exp(8'd3, 20'h12B4D, 1'b1);
        tick();
        do_read_exp(8'd3, 20'h12B4D, 1'b1);
        tick();
        do_read_exp(8'hF0, 20'h0, 1'b0);
        tick();
        chk("err_oor", 32'(bus.access_err), 32'd0);

        // Clear with an access attempt in clear cycle 5
        bus.clear_start = 1'b1;
        tick();
        chk("clr1_start_busy", 32'(bus.clear_busy), 32'd1);
        busy_ticks("clr1", 4);
        bus.rd_en        = 1'b1;
        bus.rd_addr      = 8'd2;
        bus.wr_en        = 1'b1;
        bus.wr_addr      = 8'd2;
        bus.wr_data      = 20'h00000;
        bus.wr_lane_mask = 4'b1111;
        tick();
        chk("clr1_inj_busy", 32'(bus.clear_busy), 32'd1);
        chk("err_set", 32'(bus.access_err), 32'd1);
        busy_ticks("clr1", 10);
        finish_clear("clr1");
        chk("err_sticky", 32'(bus.access_err), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            do_read_exp(8'(i), 20'hFFFFF, 1'b1);
            tick();
        end
        chk("err_sticky2", 32'(bus.access_err), 32'd1);

        // Read in the last IDLE cycle, then reset in clear cycle 9
        bus.clear_start = 1'b1;
        do_read_exp(8'd5, 20'hFFFFF, 1'b1);
        tick();
        chk("clr2_start_busy", 32'(bus.clear_busy), 32'd1);
        busy_ticks("clr2", 8);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
        chk("mid_rst_err", 32'(bus.access_err), 32'd0);
        chk("mid_rst_busy", 32'(bus.clear_busy), 32'd1);
        tick();
        rst = 1'b0;
        busy_ticks("clr3", 5);
        bus.clear_start = 1'b1;
        busy_ticks("clr3", 10);
        finish_clear("clr3");
        chk("err_after_rst", 32'(bus.access_err), 32'd0);

        // Fill every word, overlay masked writes, then 16 back-to-back reads
        for (int i = 0; i < DEPTH; i++) begin
            pat = 20'((i + 1) * 32'h0B3C5) ^ 20'h5A5A5;
            do_write(8'(i), pat, 4'b1111);
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            pat = 20'((i + 7) * 32'h1D2E9);
            do_write(8'(i), pat, 4'(i));
            tick();
        end
        for (int i = 0; i < DEPTH; i++) begin
            do_read(8'(i));
            tick();
        end
        tick();
        chk("rd_hold_end", 32'(bus.rd_data), 32'(exp_hold));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
